// File: rtl/div_iter_unit.sv
// Radix-2 restoring DIV/DIVU/REM/REMU: done XLEN+1 cycles after start (1 for special cases), stalls while iterating.
// Optional last-result cache for back-to-back DIV/REM on the same operands: `DIV_RESULT_CACHE_EN.
module div_iter_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [XLEN-1:0] alu_d_result_o,
  output logic            div_done_o,
  output logic            div_stall_o
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t          state;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q, result_q;
  logic [CW-1:0]   cnt_q;
  logic            op_rem_q, neg_quo_q, neg_rem_q, done_q;

  logic            is_signed, rs1_neg, rs2_neg, div_zero, overflow, special;
  logic            cache_hit, fast_path, accept, last_iter, quo_bit;
  logic [XLEN-1:0] rs1_mag, rs2_mag, sp_quo, sp_rem, hit_val;
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] rem_nxt, quo_nxt, quo_fin, rem_fin;

  assign is_signed = ~op_i[0];
  assign rs1_neg   = is_signed & rs1_i[XLEN-1];
  assign rs2_neg   = is_signed & rs2_i[XLEN-1];
  assign rs1_mag   = rs1_neg ? ({XLEN{1'b0}} - rs1_i) : rs1_i;
  assign rs2_mag   = rs2_neg ? ({XLEN{1'b0}} - rs2_i) : rs2_i;

  // Special cases are decided on the raw operands and never enter CALC.
  assign div_zero  = (rs2_i == {XLEN{1'b0}});
  assign overflow  = is_signed & (rs1_i == MIN_VAL) & (rs2_i == {XLEN{1'b1}});
  assign special   = div_zero | overflow;
  assign sp_quo    = div_zero ? {XLEN{1'b1}} : MIN_VAL;
  assign sp_rem    = div_zero ? rs1_i : {XLEN{1'b0}};

  assign accept    = (state == IDLE) & start_i & ~kill_i;
  assign fast_path = special | cache_hit;
  assign last_iter = (cnt_q == CW'(1));

  assign div_stall_o    = (accept & ~fast_path) | (state == CALC);
  assign div_done_o     = done_q;
  assign alu_d_result_o = result_q;

  // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign trial   = shifted - {1'b0, dvsr_q};
  assign quo_bit = ~trial[XLEN];
  assign rem_nxt = quo_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_nxt = {quo_q[XLEN-2:0], quo_bit};
  assign quo_fin = neg_quo_q ? ({XLEN{1'b0}} - quo_nxt) : quo_nxt;
  assign rem_fin = neg_rem_q ? ({XLEN{1'b0}} - rem_nxt) : rem_nxt;

`ifdef DIV_RESULT_CACHE_EN
  logic            cache_vld_q, cache_signed_q, signed_q;
  logic [XLEN-1:0] cache_rs1_q, cache_rs2_q, cache_quo_q, cache_rem_q, rs1_q, rs2_q;

  assign cache_hit = cache_vld_q & (rs1_i == cache_rs1_q) & (rs2_i == cache_rs2_q)
                   & (is_signed == cache_signed_q);
  assign hit_val   = op_i[1] ? cache_rem_q : cache_quo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_vld_q    <= 1'b0;
      cache_signed_q <= 1'b0;
      signed_q       <= 1'b0;
      cache_rs1_q    <= '0;
      cache_rs2_q    <= '0;
      cache_quo_q    <= '0;
      cache_rem_q    <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
    end else if (kill_i) begin
      cache_vld_q <= 1'b0;
    end else begin
      if (accept && !fast_path) begin
        rs1_q    <= rs1_i;
        rs2_q    <= rs2_i;
        signed_q <= is_signed;
      end
      if (accept && special) begin
        cache_vld_q    <= 1'b1;
        cache_rs1_q    <= rs1_i;
        cache_rs2_q    <= rs2_i;
        cache_signed_q <= is_signed;
        cache_quo_q    <= sp_quo;
        cache_rem_q    <= sp_rem;
      end else if (state == CALC && last_iter) begin
        cache_vld_q    <= 1'b1;
        cache_rs1_q    <= rs1_q;
        cache_rs2_q    <= rs2_q;
        cache_signed_q <= signed_q;
        cache_quo_q    <= quo_fin;
        cache_rem_q    <= rem_fin;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_val   = {XLEN{1'b0}};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      op_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (kill_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              op_rem_q  <= op_i[1];
              neg_quo_q <= rs1_neg ^ rs2_neg;
              neg_rem_q <= rs1_neg;
              if (special) begin
                result_q <= op_i[1] ? sp_rem : sp_quo;
                done_q   <= 1'b1;
                state    <= DONE;
              end else if (cache_hit) begin
                result_q <= hit_val;
                done_q   <= 1'b1;
                state    <= DONE;
              end else begin
                rem_q  <= '0;
                quo_q  <= rs1_mag;
                dvsr_q <= rs2_mag;
                cnt_q  <= CW'(XLEN);
                state  <= CALC;
              end
            end
          end
          CALC: begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q - CW'(1);
            if (last_iter) begin
              result_q <= op_rem_q ? rem_fin : quo_fin;
              done_q   <= 1'b1;
              state    <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Iterative radix-2 restoring divider for the M-extension DIV/DIVU/REM/REMU instructions.
- Accepts operands from the execute stage and holds the pipeline stalled while it iterates.
- Produces the `alu_d_result` word that the writeback mux selects under RD_WRB_D_ALU, with a one-cycle done pulse.
- It is the transmitting end of the divider-to-writeback interface.

Parameters:
- XLEN, 32, operand/result width; must be even and >= 8.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  request a division; sampled only in IDLE.
- kill_i  input  1  pipeline flush; aborts any operation.
- op_i  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU; sampled with start_i.
- rs1_i  input  XLEN  dividend.
- rs2_i  input  XLEN  divisor.
- alu_d_result_o  output  XLEN  registered result to writeback; held until the next completed operation.
- div_done_o  output  1  one-cycle pulse; alu_d_result_o valid in the same cycle.
- div_stall_o  output  1  stall request to forward/stall unit.

Behaviour:
- Reset:
  - state=IDLE, alu_d_result_o=0, div_done_o=0, div_stall_o=0.
  - All internal registers (remainder, quotient, counter, flags) are cleared to 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - On start_i=1 and kill_i=0, latch op, the signedness flags and the sign of each operand.
  - Convert operands to magnitudes for signed ops: unsigned two's-complement negate; MIN stays 0x80..0.
  - Load counter=XLEN.
- Special cases, detected in IDLE from the raw operands and bypassing CALC. Next state is DONE with the result register loaded directly:
  - divisor==0: quotient = all ones; remainder = rs1.
  - Signed (DIV/REM) with rs1=MIN and rs2=all ones: quotient = MIN; remainder = 0.
- Otherwise next state is CALC.
- CALC:
  - One quotient bit per cycle.
  - {rem,quo} shifted left 1; trial = rem_shifted - divisor as an (XLEN+1)-bit subtraction.
  - If the trial is non-negative, rem = trial and the quotient LSB = 1.
  - The counter decrements each cycle. When the counter reaches 1, the next state is DONE.
  - At the CALC-to-DONE transition, alu_d_result_o is loaded with the sign-corrected value:
    - DIV: the quotient is negated iff the operand signs differ.
    - REM: the remainder is negated iff the dividend was negative.
    - DIVU/REMU: no correction.
- DONE:
  - div_done_o=1 for exactly this one cycle.
  - Next state is IDLE unconditionally.
  - start_i is ignored in DONE.
- Latency, with the start edge at k:
  - Normal operation: div_done_o is high in the cycle after edge k+XLEN.
  - Special case: div_done_o is high in the cycle after edge k.
- div_stall_o:
  - Combinational: (state==IDLE & start_i & ~kill_i & ~fast_path) | (state==CALC).
  - It is low in DONE, so the instruction advances while the result is valid.
  - fast_path covers the special cases and, when the optional feature is compiled in, cache hits.
- start_i outside IDLE is ignored (no queueing).
- kill_i:
  - In any state, the next state is IDLE and div_done_o is not asserted.
  - alu_d_result_o keeps its prior value.
  - kill_i and start_i together in IDLE: kill_i wins.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous).

Optional Feature:
- Macro: DIV_RESULT_CACHE_EN.
- With the macro defined:
  - Registers the last completed rs1, rs2 and signedness, plus both the final quotient and remainder.
  - A valid bit is set on completion and cleared by kill_i or reset.
  - Cache hit: start_i in IDLE with identical rs1/rs2/signedness and valid=1. The unit goes straight to DONE, selecting quotient or remainder by op_i[1].
  - On a hit, div_stall_o=0 and the latency is 1, as for the special cases.
  - Intended for DIV immediately followed by REM on the same operands.
- Without the macro, no cache logic exists and every non-special operation takes the full XLEN iterations.

Test Plan:
- DIVU rs1=100, rs2=7 -> div_done_o after XLEN iterations (33rd cycle after start edge), alu_d_result_o=14; REMU same -> 2.
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> 0xFFFFFFFD (-3); REM same -> 0xFFFFFFFF (-1); div_stall_o high for exactly 32 CALC cycles.
- DIVU rs1=0x1234, rs2=0 -> 0xFFFFFFFF; REMU -> 0x1234. Both complete 1 cycle after start, div_stall_o never high.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000; REM -> 0. Both with 1-cycle latency.
- Start DIVU 100/7, assert kill_i at CALC cycle 10 -> IDLE next edge, no div_done_o, alu_d_result_o unchanged. A following start 9/3 returns 3. kill_i+start_i in the same cycle -> no operation starts.
- With DIV_RESULT_CACHE_EN: DIV 1000/-3 -> -333 at full latency, then REM 1000/-3 -> 1 with done in the next cycle, no stall. A REMU on the same operands (signedness differs) -> full latency.
